// File: rtl/run_ctrl_pkg.sv
// Shared state encoding, divider default and period helper for the run controller.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_RUN   = 3'd2,
    ST_STEP  = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam int unsigned RC_DIV_DEFAULT = 32'd2000000;

  // A requested period of zero selects the build-time default.
  function automatic logic [31:0] eff_period(input logic [31:0] req, input logic [31:0] dflt);
    return (req == 32'd0) ? dflt : req;
  endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// Byte-receive and program-memory write bundle between UART, controller and pmem.
interface run_ctrl_if;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        pmem_we;
  logic [31:0] pmem_addr;
  logic [31:0] pmem_wdata;

  modport master (
    input  rx_valid, rx_byte,
    output pmem_we, pmem_addr, pmem_wdata
  );

  modport slave (
    output rx_valid, rx_byte,
    input  pmem_we, pmem_addr, pmem_wdata
  );
endinterface

// File: rtl/run_ctrl_ce_div.sv
// Clock-enable divider: latches the period on clear, then flags the last count of each period.
// slot is combinational from registered state and only asserts while enable is high.
module ce_div
  import run_ctrl_pkg::*;
#(
  parameter int unsigned DIV_DEFAULT = RC_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [31:0] period,
  output logic        slot
);

  logic [31:0] per_q;
  logic [31:0] cnt_q;

  assign slot = enable && (cnt_q == per_q - 32'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      per_q <= 32'd1;
      cnt_q <= '0;
    end else if (clear) begin
      per_q <= eff_period(period, DIV_DEFAULT);
      cnt_q <= '0;
    end else if (enable) begin
      if (slot) cnt_q <= '0;
      else      cnt_q <= cnt_q + 32'd1;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Execution controller: loads program bytes into pmem, then paces the core via core_ce
// through run/step/halt with a PC breakpoint; pmem writes land one cycle after the 4th byte.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned DIV_DEFAULT = RC_DIV_DEFAULT,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  run_ctrl_if.master       bus,
  input  logic             load_req,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic [31:0]      div_period,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      core_pc,
  output logic             core_ce,
  output logic             core_reset,
  output logic             mode,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] load_count,
  output logic             load_ovf
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic [23:0]      word_q;
  logic             ovf_q;
  logic             exempt_q;
  logic             we_q;
  logic [31:0]      addr_q, wdata_q, word_addr;
  logic             rx_take, ce_slot, div_clear, bp_hit;

  assign rx_take   = (state_q == ST_LOAD) && bus.rx_valid && !(&cnt_q);
  assign cnt_next  = rx_take ? cnt_q + 1'b1 : cnt_q;
  assign bp_hit    = bp_en && (core_pc == bp_addr) && !exempt_q;
  assign div_clear = (state_d == ST_RUN) && (state_q != ST_RUN);

  always_comb begin
    word_addr = '0;
    word_addr[CNT_W-1:0] = {cnt_q[CNT_W-1:2], 2'b00};
  end

  ce_div #(
    .DIV_DEFAULT (DIV_DEFAULT)
  ) u_ce_div (
    .clk    (clk),
    .reset  (reset),
    .clear  (div_clear),
    .enable (state_q == ST_RUN),
    .period (div_period),
    .slot   (ce_slot)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    core_ce = 1'b0;
    case (state_q)
      ST_LOAD: begin
        // The byte arriving alongside run_req is already counted in cnt_next.
        if (run_req) state_d = (cnt_next[1:0] != 2'b00) ? ST_FLUSH : ST_RUN;
      end
      ST_FLUSH: state_d = ST_RUN;
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (ce_slot) begin
          if (bp_hit) state_d = ST_HALT;
          else        core_ce = 1'b1;
        end
      end
      ST_STEP: begin
        core_ce = 1'b1;
        state_d = ST_HALT;
      end
      ST_HALT: begin
        if      (load_req) state_d = ST_LOAD;
        else if (run_req)  state_d = ST_RUN;
        else if (step_req) state_d = ST_STEP;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Resuming from HALT lets the first ce leave a PC that sits on the breakpoint.
  always_ff @(posedge clk) begin
    if (reset) begin
      exempt_q <= 1'b0;
    end else if (state_q == ST_HALT && state_d == ST_RUN) begin
      exempt_q <= 1'b1;
    end else if (state_d != ST_RUN || ce_slot) begin
      exempt_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      word_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= 1'b0;
      if (state_q == ST_HALT && state_d == ST_LOAD) begin
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
        word_q <= '0;
      end else if (state_q == ST_LOAD) begin
        if (bus.rx_valid && (&cnt_q)) ovf_q <= 1'b1;
        if (rx_take) begin
          cnt_q <= cnt_next;
          case (cnt_q[1:0])
            2'd0: word_q[7:0]   <= bus.rx_byte;
            2'd1: word_q[15:8]  <= bus.rx_byte;
            2'd2: word_q[23:16] <= bus.rx_byte;
            default: begin
              we_q    <= 1'b1;
              addr_q  <= word_addr;
              wdata_q <= {bus.rx_byte, word_q};
              word_q  <= '0;
            end
          endcase
        end
      end else if (state_q == ST_FLUSH) begin
        // Unfilled lanes are already zero since the buffer clears after every write.
        we_q    <= 1'b1;
        addr_q  <= word_addr;
        wdata_q <= {8'h00, word_q};
        word_q  <= '0;
      end
    end
  end

  assign bus.pmem_we    = we_q;
  assign bus.pmem_addr  = addr_q;
  assign bus.pmem_wdata = wdata_q;
  assign core_reset     = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
  assign mode           = !core_reset;
  assign state_o        = state_q;
  assign load_count     = cnt_q;
  assign load_ovf       = ovf_q;

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
Execution controller for the core, placed between the UART byte receiver, program memory and the core.
- Owns the program-memory write port while loading.
- Sequences the core through load, free-run, single-step and halt.
- Paces execution with a clock-enable pulse; no derived clock is used.
- Stops the core on a PC breakpoint.

Parameters:
DIV_DEFAULT, 2000000, core_ce period in clk cycles, used when div_period input is 0
CNT_W, 16, width of the loaded-byte counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_valid  in  1  one-cycle pulse, rx_byte valid
rx_byte  in  8  received byte
load_req  in  1  pulse, enter LOAD (accepted in HALT only)
run_req  in  1  pulse, start/resume free-run
step_req  in  1  pulse, execute one instruction (HALT only)
halt_req  in  1  pulse, stop free-run
div_period  in  32  ce period in clk cycles; 0 means use DIV_DEFAULT
bp_en  in  1  breakpoint enable
bp_addr  in  32  breakpoint PC
core_pc  in  32  PC of next instruction to execute
core_ce  out  1  one-cycle enable; core advances one instruction per pulse
core_reset  out  1  holds core in reset
pmem_we  out  1  program memory write strobe
pmem_addr  out  32  byte address of write
pmem_wdata  out  32  write data
mode  out  1  0 = LOAD/FLUSH, 1 = RUN/STEP/HALT
state_o  out  3  current state encoding
load_count  out  CNT_W  bytes accepted since entering LOAD
load_ovf  out  1  sticky; byte dropped because the counter is saturated

Behaviour:
- Reset values: state LOAD, core_reset=1, core_ce=0, pmem_we=0, pmem_addr=0, pmem_wdata=0, mode=0, load_count=0, load_ovf=0, word buffer=0.
- States: LOAD, FLUSH, RUN, STEP, HALT.
- LOAD:
  - core_reset=1.
  - rx_valid stores rx_byte into lane load_count[1:0], little-endian (byte 0 -> bits 7:0), then increments load_count.
  - When the 4th lane is stored, the next cycle drives pmem_we=1 for exactly one cycle, with pmem_addr={load_count_at_lane0[CNT_W-1:2],2'b00} zero-extended and pmem_wdata = the assembled word.
  - Word buffer clears after each write.
  - If load_count=all-ones, further bytes are dropped and load_ovf is set.
  - rx_valid outside LOAD is ignored.
- LOAD + run_req:
  - A byte arriving in the same cycle is accepted first.
  - If load_count[1:0]!=0 -> FLUSH: the partial word is written once, unfilled lanes zero, then -> RUN.
  - Otherwise -> RUN directly.
  - step_req and halt_req are ignored in LOAD.
- RUN entry:
  - core_reset=0, mode=1.
  - Divider counter cleared.
  - Period P latched (div_period, or DIV_DEFAULT if 0).
  - core_reset stays 0 in RUN/STEP/HALT.
- RUN:
  - Counter counts 0..P-1; core_ce=1 in the cycle the counter equals P-1, then wraps to 0.
  - P=1 gives ce every cycle.
  - First ce occurs P cycles after entry.
- RUN priority each cycle: halt_req > breakpoint > ce.
  - halt_req -> HALT next cycle; no ce in that cycle.
  - Breakpoint: if bp_en && core_pc==bp_addr in a cycle where ce would fire, ce is suppressed and state -> HALT. The instruction at bp_addr has not executed.
- Resume exemption: after resume from HALT via run_req, the first ce of that run skips the breakpoint check, so execution can leave bp_addr.
- HALT priority: load_req > run_req > step_req.
  - load_req -> LOAD: core_reset=1, load_count=0, load_ovf=0, buffer cleared.
  - run_req -> RUN.
  - step_req -> STEP.
- STEP: core_ce=1 for exactly one cycle, with no breakpoint check, then -> HALT.
- reset at any time, including mid-word or mid-divide: return to reset values next edge. A partial word is discarded, not written.
- state_o encoding: LOAD=0, FLUSH=1, RUN=2, STEP=3, HALT=4.

Decomposition:
- Package run_ctrl_pkg: state_t enum (encodings above), DIV_DEFAULT default value.
- Sub-module ce_div: period latch, counter and ce pulse generation, with clear and enable inputs.
- Word assembly and state machine stay in run_ctrl.

Test Plan:
- Load: send 8 bytes 01..08 -> pmem_we pulses twice; writes (addr 0, 0x04030201) and (addr 4, 0x08070605); load_count=8; core_reset=1 throughout.
- Flush: send 6 bytes 01..06, then run_req -> FLUSH writes (addr 4, 0x00000605); RUN next; core_reset=0.
- Pacing: div_period=3 in RUN -> core_ce pulses on cycles 3,6,9 after entry; div_period=0 -> ce period = DIV_DEFAULT.
- Breakpoint: bp_en=1, bp_addr=0x10; core_pc reaches 0x10 -> no ce at that slot, state HALT. Then run_req -> first ce fires at 0x10 and run continues.
- Halt/step: halt_req in the same cycle as a ce slot -> no ce, HALT. step_req -> exactly one ce pulse, back to HALT. step_req and run_req together -> RUN.
- Reset mid-word: 3 bytes sent, then reset -> no pmem_we ever; all outputs at reset values; a fresh 4-byte load writes to addr 0.
